// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the AtomRV data-side load/store unit: access sizes,
// FSM states and the default bus timeout.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane steering for byte/half/word accesses --
// byte selects, replicated store data, extended load data, misalign flag.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata_i >> {off_i, 3'b000};
    sel_o      = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (size_i)
      LSU_SIZE_B: begin
        sel_o   = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      LSU_SIZE_H: begin
        sel_o      = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        misalign_o = off_i[0];
      end
      LSU_SIZE_W: begin
        sel_o      = 4'b1111;
        rdata_o    = shifted;
        misalign_o = (off_i != 2'b00);
      end
      default: begin
        sel_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine turning core requests into
// word-aligned bus cycles. Optional bus timeout enabled by LSU_TIMEOUT_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request transfers on the clock edge where req_valid_i and
  // req_ready_o are both high; resp_valid_o is a single-cycle pulse, no ready.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES out of range 1..65535");
  end

  lsu_state_e  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle, busy;
  logic [1:0]  al_size, al_off;
  logic        al_uns;
  logic [31:0] al_wdata_in;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata, al_rdata;
  logic        al_misalign;

  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_BUSY);

  // In IDLE the aligner judges the incoming request; afterwards it works
  // from the latched request so bus outputs stay stable through BUSY.
  assign al_size     = idle ? req_size_i     : size_q;
  assign al_off      = idle ? req_addr_i[1:0] : off_q;
  assign al_uns      = idle ? req_unsigned_i : uns_q;
  assign al_wdata_in = idle ? req_wdata_i    : wdata_q;

  lsu_align u_align (
    .size_i     (al_size),
    .off_i      (al_off),
    .unsigned_i (al_uns),
    .wdata_i    (al_wdata_in),
    .rdata_i    (mem_data_i),
    .sel_o      (al_sel),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i[31:2];
          off_d   = req_addr_i[1:0];
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          rdata_d = 32'h0;
          if (req_size_i == 2'b11 || al_misalign) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_BUSY;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = 16'h0;
`endif
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          rdata_d = we_q ? 32'h0 : al_rdata;
          state_d = ST_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TO_LIMIT) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = ST_RESP;
          end
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= 30'h0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 16'h0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready_o  = idle;
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = resp_valid_o ? rdata_q : 32'h0;
  assign resp_err_o   = resp_valid_o & err_q;
  assign mem_stb_o    = busy;
  assign mem_we_o     = busy & we_q;
  assign mem_addr_o   = busy ? {addr_q, 2'b00} : 32'h0;
  assign mem_sel_o    = busy ? al_sel : 4'b0000;
  assign mem_data_o   = busy ? al_wdata : 32'h0;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// requests scored against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i = 32'h0;
  logic        mem_ack_i = 1'b0;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  // clock / reset
  always #5 clk_i = ~clk_i;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_stb_o      (mem_stb_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_sel_o      (mem_sel_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .dbg_state_o    (dbg_state_o)
  );

  // reference model
  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    int bytes;
    if (size == 2'd3) return 1'b1;
    bytes = 1 << size;
    return (addr % bytes) != 0;
  endfunction

  function automatic logic [31:0] m_sel(input logic [1:0] size, input logic [31:0] addr);
    int lanes;
    lanes = (1 << (1 << size)) - 1;
    return 32'((lanes << (addr % 4)) & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
    if (size == 2'd0) return wdata[7:0] * 32'h0101_0101;
    if (size == 2'd1) return wdata[15:0] * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] bus);
    longint unsigned v, mask;
    int nbits;
    nbits = 8 << size;
    mask  = (64'd1 << nbits) - 64'd1;
    v     = (64'(bus) >> (8 * (addr % 4))) & mask;
    if (!uns && ((v >> (nbits - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one request, optional wait-states, full response check
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] bus);
    logic        err;
    logic [32:0] e;
    @(negedge clk_i);
    chk("ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    err = m_err(size, addr);
    exp_q.push_back({err, (err || we) ? 32'h0 : m_rdata(size, uns, addr, bus)});
    if (!err) begin
      for (int k = 0; k <= waits; k++) begin
        chk("busy_stb", {31'b0, mem_stb_o}, 32'd1);
        chk("busy_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        chk("busy_sel", {28'b0, mem_sel_o}, m_sel(size, addr));
        chk("busy_we", {31'b0, mem_we_o}, {31'b0, we});
        if (we) chk("busy_wdata", mem_data_o, m_wdata(size, wdata));
        chk("busy_no_resp", {31'b0, resp_valid_o}, 32'd0);
        chk("busy_not_ready", {31'b0, req_ready_o}, 32'd0);
        mem_ack_i  = (k == waits);
        mem_data_i = (k == waits) ? bus : $urandom;
        @(posedge clk_i); #1;
        mem_ack_i  = 1'b0;
        mem_data_i = $urandom;
      end
    end
    chk("resp_valid", {31'b0, resp_valid_o}, 32'd1);
    chk("resp_stb_low", {31'b0, mem_stb_o}, 32'd0);
    chk("resp_not_ready", {31'b0, req_ready_o}, 32'd0);
    e = exp_q.pop_front();
    chk("resp_rdata", resp_rdata_o, e[31:0]);
    chk("resp_err", {31'b0, resp_err_o}, {31'b0, e[32]});
    @(posedge clk_i); #1;
    chk("resp_one_pulse", {31'b0, resp_valid_o}, 32'd0);
    chk("ready_back", {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #3;
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_stb", {31'b0, mem_stb_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_sel", {28'b0, mem_sel_o}, 32'h0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // directed cases
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_1234);  // LB
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_1234);  // LBU
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'hDEAD_BEEF, 0, 32'h0);  // SH
    do_req(1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 0, 32'h0);          // LW misaligned
    do_req(1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 0, 32'h0);          // illegal size
    do_req(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 3, 32'h1234_5678);  // LW, 3 waits
    do_req(1'b0, 2'd1, 1'b0, 32'h306, 32'h0, 1, 32'h9ABC_0000);  // LH upper half

    // ack outside BUSY is ignored
    mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk("stray_ack_no_resp", {31'b0, resp_valid_o}, 32'd0);
    chk("stray_ack_ready", {31'b0, req_ready_o}, 32'd1);

    // async reset during the second BUSY cycle, then a late ack
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h400;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("rst_busy1_stb", {31'b0, mem_stb_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("rst_busy2_stb", {31'b0, mem_stb_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst_stb", {31'b0, mem_stb_o}, 32'd0);
    chk("async_rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("async_rst_resp", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_ack_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk("late_ack_no_resp", {31'b0, resp_valid_o}, 32'd0);
    chk("late_ack_no_stb", {31'b0, mem_stb_o}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, 32'hCAFE_F00D);

`ifdef LSU_TIMEOUT_EN
    // no ack: strobe for exactly four cycles, then an error response
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h500;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to_stb", {31'b0, mem_stb_o}, 32'd1);
      @(posedge clk_i); #1;
    end
    chk("to_stb_low", {31'b0, mem_stb_o}, 32'd0);
    chk("to_resp_valid", {31'b0, resp_valid_o}, 32'd1);
    chk("to_resp_err", {31'b0, resp_err_o}, 32'd1);
    chk("to_resp_rdata", resp_rdata_o, 32'h0);
    @(posedge clk_i); #1;
    do_req(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 3, 32'h0BAD_CAFE);  // ack on 4th
`endif

    // random traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, int'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
